// File: rtl/uart_rx_ff.sv
// uart_rx_ff: 8N1 UART receiver feeding the write port of a downstream sync_fifo.
// The rx pin is synchronized by two flops, then an oversampling FSM samples each
// bit at its centre. The FSM delivers good bytes as one-cycle write strobes. It
// flags a low stop bit as a framing error. It flags a byte that cannot be written
// because the FIFO is full as an overrun.
module uart_rx_ff #(
    parameter int BAUD_CYCLE = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       ffFull,
    output logic       wrEn,
    output logic [7:0] wrData,
    output logic       frameErr,
    output logic       overrun,
    output logic       busy
);

    localparam int CW   = (BAUD_CYCLE > 1) ? $clog2(BAUD_CYCLE) : 1;
    localparam int HALF = BAUD_CYCLE / 2;

    // The counter restarts at zero on every state entry and after every sample.
    // A sample point of N cycles is therefore reached when the count reads N-1.
    localparam logic [CW-1:0] CNT_ONE       = CW'(1);
    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(BAUD_CYCLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_e;

    state_e        state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [2:0]    bit_idx_q,   bit_idx_d;
    logic [7:0]    shift_q,     shift_d;
    logic          sync1_q,     sync1_d;
    logic          sync2_q,     sync2_d;
    logic          wr_en_q,     wr_en_d;
    logic [7:0]    wr_data_q,   wr_data_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q,   overrun_d;
    logic          busy_q,      busy_d;
    logic          rx_s;

    // Two-stage synchronizer path for the asynchronous rx pin.
    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
    end

    assign rx_s = sync2_q;

    // Next-state, datapath and output pulse logic of the receive FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_ONE;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                // Re-check the start bit at its centre to reject short glitches.
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    state_d = ST_START;
                end
            end

            ST_DATA: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end

            ST_STOP: begin
                // Leave at mid stop bit so that a start edge on the next boundary is caught.
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                        if (ffFull) begin
                            overrun_d = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_data_d = shift_q;
                        end
                    end else begin
                        state_d     = ST_WAIT_HIGH;
                        frame_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end

            ST_WAIT_HIGH: begin
                // A held-low (break) line must not retrigger a new frame.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            wr_en_q     <= 1'b0;
            wr_data_q   <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign wrEn     = wr_en_q;
    assign wrData   = wr_data_q;
    assign frameErr = frame_err_q;
    assign overrun  = overrun_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_rx_ff.sv
// Self-checking bench for uart_rx_ff at 16 clocks per bit. Expected events are
// queued as frames are driven. A negedge monitor pops and compares them as
// wrEn / overrun / frameErr pulses appear.
module tb_uart_rx_ff;

    localparam int BAUD = 16;

    localparam logic [3:0] K_WR   = 4'h1;
    localparam logic [3:0] K_OVR  = 4'h2;
    localparam logic [3:0] K_FERR = 4'h3;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       ffFull;
    logic       wrEn;
    logic [7:0] wrData;
    logic       frameErr;
    logic       overrun;
    logic       busy;

    int n_cmp;
    int n_err;
    int cyc;
    int n_events;
    int gap_cnt;
    int wr_gap;
    int last_wr_cyc;
    int last_start_cyc;

    logic [11:0] exp_q[$];
    logic [11:0] mon_obs;
    logic [11:0] mon_exp;

    uart_rx_ff #(.BAUD_CYCLE(BAUD)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .ffFull   (ffFull),
        .wrEn     (wrEn),
        .wrData   (wrData),
        .frameErr (frameErr),
        .overrun  (overrun),
        .busy     (busy)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for latency checks.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: compares each output pulse against the scoreboard and tracks busy-low gaps.
    always @(negedge clk) begin
        if (!rst && (wrEn || frameErr || overrun)) begin
            n_events++;
            mon_obs = {(wrEn ? K_WR : (overrun ? K_OVR : K_FERR)), (wrEn ? wrData : 8'h00)};
            check("pulse_exclusive", 32'(wrEn) + 32'(frameErr) + 32'(overrun), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(mon_obs), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("event", 32'(mon_obs), 32'(mon_exp));
            end
        end
        if (wrEn) begin
            wr_gap      = gap_cnt;
            gap_cnt     = 1;
            last_wr_cyc = cyc;
        end else if (!busy) begin
            gap_cnt = gap_cnt + 1;
        end
    end

    // Drives one 8N1 frame starting on a negedge; the line returns high afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        last_start_cyc = cyc;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BAUD) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Directed stimulus sequence.
    initial begin
        n_cmp          = 0;
        n_err          = 0;
        cyc            = 0;
        n_events       = 0;
        gap_cnt        = 0;
        wr_gap         = 0;
        last_wr_cyc    = 0;
        last_start_cyc = 0;
        rst            = 1'b1;
        rx             = 1'b1;
        ffFull         = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_wrEn",     32'(wrEn),     32'd0);
        check("reset_wrData",   32'(wrData),   32'h00);
        check("reset_frameErr", 32'(frameErr), 32'd0);
        check("reset_overrun",  32'(overrun),  32'd0);
        check("reset_busy",     32'(busy),     32'd0);

        // Single frame and its latency from the pin edge (2 sync + 8 + 144 + 1).
        idle_cycles(20);
        exp_q.push_back({K_WR, 8'hA5});
        send_frame(8'hA5, 1'b1);
        check("a5_latency", 32'(last_wr_cyc - last_start_cyc), 32'd155);
        idle_cycles(30);
        check("a5_hold_wrData", 32'(wrData), 32'hA5);
        check("a5_idle_busy",   32'(busy),   32'd0);

        // Back-to-back frames; busy is low for 8 cycles between consecutive frames.
        exp_q.push_back({K_WR, 8'h00});
        exp_q.push_back({K_WR, 8'hFF});
        exp_q.push_back({K_WR, 8'h55});
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        check("b2b_gap_ff", 32'(wr_gap), 32'd8);
        send_frame(8'h55, 1'b1);
        check("b2b_gap_55", 32'(wr_gap), 32'd8);
        idle_cycles(30);

        // Overrun with FIFO full, then the same byte accepted.
        ffFull = 1'b1;
        exp_q.push_back({K_OVR, 8'h00});
        send_frame(8'h3C, 1'b1);
        idle_cycles(30);
        check("ovr_wrData_held", 32'(wrData), 32'h55);
        ffFull = 1'b0;
        exp_q.push_back({K_WR, 8'h3C});
        send_frame(8'h3C, 1'b1);
        idle_cycles(30);

        // Framing error followed by a long break; exactly one frameErr.
        exp_q.push_back({K_FERR, 8'h00});
        send_frame(8'h81, 1'b0);
        rx = 1'b0;
        repeat (40 * BAUD) @(negedge clk);
        check("break_busy", 32'(busy), 32'd1);
        idle_cycles(40);
        check("break_release_busy", 32'(busy), 32'd0);
        check("break_wrData_held",  32'(wrData), 32'h3C);

        // Short glitch rejected, then a valid frame.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy", 32'(busy), 32'd1);
        idle_cycles(20);
        check("glitch_idle_busy", 32'(busy), 32'd0);
        exp_q.push_back({K_WR, 8'h5A});
        send_frame(8'h5A, 1'b1);
        idle_cycles(30);

        // Reset during bit 4 of a frame: partial byte discarded.
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (BAUD) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BAUD / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy",     32'(busy),     32'd0);
        check("midrst_wrData",   32'(wrData),   32'h00);
        check("midrst_wrEn",     32'(wrEn),     32'd0);
        check("midrst_frameErr", 32'(frameErr), 32'd0);
        check("midrst_overrun",  32'(overrun),  32'd0);
        idle_cycles(200);
        check("midrst_idle_busy", 32'(busy), 32'd0);
        exp_q.push_back({K_WR, 8'h12});
        send_frame(8'h12, 1'b1);
        idle_cycles(50);

        check("final_wrData",      32'(wrData),       32'h12);
        check("scoreboard_empty",  32'(exp_q.size()), 32'd0);
        check("total_events",      32'(n_events),     32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
